if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 85 ++++++++
 tb/tb_if_fetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch PC register with redirect, delay-slot tracking and fetch fault (optional range check: IF_RANGE_CHECK_EN)
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        npc_sel,
    input  logic [31:0] npc,
    input  logic        id_is_branch,
    output logic [31:0] i_addr,
    input  logic [31:0] i_rdata,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_instr,
    output logic [4:0]  IF_ExcCode,
    output logic        IF_BD,
    output logic [31:0] fetch_cnt
);

`ifdef IF_RANGE_CHECK_EN
    localparam logic RANGE_CHECK = 1'b1;
`else
    localparam logic RANGE_CHECK = 1'b0;
`endif

    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        bd_q;
    logic [31:0] cnt_q;
    logic        misaligned;
    logic        out_of_range;
    logic        fault;

    // Exception request wins over everything except reset, even while stalled.
    always_comb begin
        pc_d = pc_q;
        if (req) begin
            pc_d = HANDLER_PC;
        end else if (enable) begin
            if (eret) begin
                pc_d = epc;
            end else if (npc_sel) begin
                pc_d = npc;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            bd_q  <= 1'b0;
            cnt_q <= 32'd0;
        end else begin
            pc_q <= pc_d;
            if (req) begin
                bd_q <= 1'b0;
            end else if (enable) begin
                bd_q  <= id_is_branch & ~eret;
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign misaligned   = (pc_q[1:0] != 2'b00);
    assign out_of_range = (pc_q < IM_LO) || (pc_q > IM_HI);
    assign fault        = misaligned | (RANGE_CHECK & out_of_range);

    assign i_addr     = pc_q;
    assign IF_PC      = pc_q;
    assign IF_BD      = bd_q;
    assign fetch_cnt  = cnt_q;
    assign IF_ExcCode = fault ? EXC_ADEL : 5'd0;
    assign IF_instr   = fault ? 32'h0 : i_rdata;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - randomized and directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] IM_LO      = 32'h0000_3000;
    localparam logic [31:0] IM_HI      = 32'h0000_6FFC;

`ifdef IF_RANGE_CHECK_EN
    localparam bit RANGE_ON = 1'b1;
`else
    localparam bit RANGE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        req = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc = 32'h0;
    logic        npc_sel = 1'b0;
    logic [31:0] npc = 32'h0;
    logic        id_is_branch = 1'b0;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic [31:0] IF_PC;
    logic [31:0] IF_instr;
    logic [4:0]  IF_ExcCode;
    logic        IF_BD;
    logic [31:0] fetch_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // reference state
    logic [31:0] m_pc;
    logic        m_bd;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    // instruction memory: a fixed, address-dependent pattern
    assign i_rdata = {i_addr[15:0], ~i_addr[31:16]};

    if_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .HANDLER_PC(HANDLER_PC),
        .IM_LO     (IM_LO),
        .IM_HI     (IM_HI)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .req         (req),
        .eret        (eret),
        .epc         (epc),
        .npc_sel     (npc_sel),
        .npc         (npc),
        .id_is_branch(id_is_branch),
        .i_addr      (i_addr),
        .i_rdata     (i_rdata),
        .IF_PC       (IF_PC),
        .IF_instr    (IF_instr),
        .IF_ExcCode  (IF_ExcCode),
        .IF_BD       (IF_BD),
        .fetch_cnt   (fetch_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit model_fault(input logic [31:0] pc);
        return (pc % 4 != 0) || (RANGE_ON && (pc < IM_LO || pc > IM_HI));
    endfunction

    // Advance the reference by one clock using the currently driven inputs, then clock the DUT.
    task automatic tick();
        if (reset) begin
            m_pc = RESET_PC; m_bd = 1'b0; m_cnt = 0;
        end else if (req) begin
            m_pc = HANDLER_PC; m_bd = 1'b0;
        end else if (enable) begin
            if (eret)         m_pc = epc;
            else if (npc_sel) m_pc = npc;
            else              m_pc = m_pc + 32'd4;
            m_bd  = id_is_branch && !eret;
            m_cnt = m_cnt + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        bit f;
        f = model_fault(m_pc);
        check({tag, "_pc"},   IF_PC, m_pc);
        check({tag, "_addr"}, i_addr, m_pc);
        check({tag, "_bd"},   {31'd0, IF_BD}, {31'd0, m_bd});
        check({tag, "_cnt"},  fetch_cnt, m_cnt);
        check({tag, "_exc"},  {27'd0, IF_ExcCode}, f ? 32'd4 : 32'd0);
        check({tag, "_ins"},  IF_instr, f ? 32'h0 : {m_pc[15:0], ~m_pc[31:16]});
    endtask

    task automatic idle_inputs();
        reset = 0; enable = 0; req = 0; eret = 0; npc_sel = 0; id_is_branch = 0;
    endtask

    task automatic redirect(input logic [31:0] target);
        idle_inputs();
        enable = 1; npc_sel = 1; npc = target;
        tick();
        check_model("redir");
    endtask

    logic [31:0] hold_pc;
    logic [31:0] hold_cnt;
    logic        hold_bd;

    initial begin
        m_pc = 32'h0; m_bd = 1'b0; m_cnt = 0;

        // reset state
        idle_inputs(); reset = 1;
        tick();
        check_model("rst");
        check("rst_pc_const", IF_PC, 32'h0000_3000);
        check("rst_exc_const", {27'd0, IF_ExcCode}, 32'd0);

        // sequential fetch
        idle_inputs(); enable = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_model("seq");
        end
        check("seq_pc_const", IF_PC, 32'h0000_300C);
        check("seq_cnt_const", fetch_cnt, 32'd3);

        // delay slot then branch target
        tick();
        check("bd_start_pc", IF_PC, 32'h0000_3010);
        id_is_branch = 1; npc_sel = 0;
        tick();
        check_model("bd1");
        check("bd1_pc_const", IF_PC, 32'h0000_3014);
        check("bd1_bd_const", {31'd0, IF_BD}, 32'd1);
        id_is_branch = 0; npc_sel = 1; npc = 32'h0000_3100;
        tick();
        check_model("bd2");
        check("bd2_pc_const", IF_PC, 32'h0000_3100);
        check("bd2_bd_const", {31'd0, IF_BD}, 32'd0);

        // request while stalled, with a competing branch
        redirect(32'h0000_3020);
        hold_cnt = fetch_cnt;
        idle_inputs(); req = 1; npc_sel = 1; npc = 32'h0000_3200; id_is_branch = 1;
        tick();
        check_model("req");
        check("req_pc_const", IF_PC, 32'h0000_4180);
        check("req_cnt_hold", fetch_cnt, hold_cnt);

        // req and eret together: handler only
        idle_inputs(); req = 1; eret = 1; enable = 1; epc = 32'h0000_3500;
        tick();
        check_model("req_eret");
        check("req_eret_pc_const", IF_PC, 32'h0000_4180);

        // eret to a misaligned epc
        idle_inputs(); eret = 1; enable = 1; epc = 32'h0000_3002; id_is_branch = 1;
        tick();
        check_model("eret");
        check("eret_pc_const", IF_PC, 32'h0000_3002);
        check("eret_exc_const", {27'd0, IF_ExcCode}, 32'd4);
        check("eret_ins_const", IF_instr, 32'h0);

        // out-of-range target
        redirect(32'h0000_7000);
        check("oor_exc_const", {27'd0, IF_ExcCode}, RANGE_ON ? 32'd4 : 32'd0);
        check("oor_ins_const", IF_instr, RANGE_ON ? 32'h0 : i_rdata);

        // boundaries of the legal window
        redirect(32'h0000_6FFC);
        check("hi_exc_const", {27'd0, IF_ExcCode}, 32'd0);
        redirect(32'h0000_2FFC);

        // PC wrap
        redirect(32'hFFFF_FFFC);
        idle_inputs(); enable = 1;
        tick();
        check_model("wrap");
        check("wrap_pc_const", IF_PC, 32'h0000_0000);

        // stall holds everything, then reset aborts it
        redirect(32'h0000_3040);
        hold_pc = IF_PC; hold_cnt = fetch_cnt; hold_bd = IF_BD;
        idle_inputs(); npc_sel = 1; npc = 32'h0000_3300; eret = 1; id_is_branch = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_model("stall");
            check("stall_pc_hold", IF_PC, hold_pc);
            check("stall_cnt_hold", fetch_cnt, hold_cnt);
            check("stall_bd_hold", {31'd0, IF_BD}, {31'd0, hold_bd});
        end
        idle_inputs(); reset = 1; enable = 1; req = 1;
        tick();
        check_model("rst2");
        check("rst2_pc_const", IF_PC, 32'h0000_3000);
        check("rst2_cnt_const", fetch_cnt, 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset        = ($urandom_range(0, 59) == 0);
            req          = ($urandom_range(0, 19) == 0);
            enable       = ($urandom_range(0, 3) != 0);
            eret         = ($urandom_range(0, 9) == 0);
            npc_sel      = ($urandom_range(0, 3) == 0);
            id_is_branch = $urandom_range(0, 1);
            npc = ($urandom_range(0, 7) == 0) ? $urandom : 32'h0000_3000 + 4 * $urandom_range(0, 4095);
            epc = ($urandom_range(0, 5) == 0) ? $urandom : 32'h0000_3000 + 4 * $urandom_range(0, 4095);
            tick();
            check_model("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
